// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings, default latencies and the arithmetic result record.
package mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_OP_NONE  = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDU_OP_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MFHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MFLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MTHI  = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDU_OP_MTLO  = 4'd8;

  // Also consumed by the hazard unit to size its stall window.
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divByZero;
  } mduArith_t;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the 64-bit {hi,lo} result.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         rs,
  input  logic [31:0]         rt,
  output mduArith_t           res
);

  logic signed [63:0] prodS;
  logic        [63:0] prodU;
  logic signed [31:0] sDvd, sDvs, sQuo, sRem;
  logic        [31:0] uDvs, uQuo, uRem;
  logic               rtZero, sOvf;

  assign rtZero = (rt == 32'd0);
  // INT_MIN / -1 overflows; dividing by 1 instead yields the wrapped quotient and zero remainder.
  assign sOvf   = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

  assign prodS = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prodU = {32'd0, rs} * {32'd0, rt};

  assign sDvd = $signed(rs);
  assign sDvs = (rtZero || sOvf) ? 32'sd1 : $signed(rt);
  assign sQuo = sDvd / sDvs;
  assign sRem = sDvd % sDvs;

  assign uDvs = rtZero ? 32'd1 : rt;
  assign uQuo = rs / uDvs;
  assign uRem = rs % uDvs;

  always_comb begin
    res = '0;
    unique case (op)
      MDU_OP_MULT:  {res.hi, res.lo} = prodS;
      MDU_OP_MULTU: {res.hi, res.lo} = prodU;
      MDU_OP_DIV: begin
        res.hi        = sRem;
        res.lo        = sQuo;
        res.divByZero = rtZero;
      end
      MDU_OP_DIVU: begin
        res.hi        = uRem;
        res.lo        = uQuo;
        res.divByZero = rtZero;
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// HI/LO register file with a fixed-latency multi-cycle window for mult/div results.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MDU_OP_W-1:0] mdu_op,
  input  logic                op_valid,
  input  logic [31:0]         rs_data,
  input  logic [31:0]         rt_data,
  output logic                busy,
  output logic [31:0]         mdu_result,
  output logic [31:0]         hi_out,
  output logic [31:0]         lo_out
);

  localparam int MaxCyc = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CntW   = $clog2(MaxCyc + 1);

  logic [31:0]     hiReg, loReg, pendHi, pendLo;
  logic            pendDbz;
  logic [CntW-1:0] cnt;
  mduArith_t       arith;

  mdu_arith uArith (
    .op  (mdu_op),
    .rs  (rs_data),
    .rt  (rt_data),
    .res (arith)
  );

  // busy is exactly "counter still running"; no separate flag to keep in sync.
  assign busy   = (cnt != '0);
  assign hi_out = hiReg;
  assign lo_out = loReg;

  always_comb begin
    mdu_result = '0;
    if (op_valid) begin
      if (mdu_op == MDU_OP_MFHI)      mdu_result = hiReg;
      else if (mdu_op == MDU_OP_MFLO) mdu_result = loReg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hiReg   <= '0;
      loReg   <= '0;
      pendHi  <= '0;
      pendLo  <= '0;
      pendDbz <= 1'b0;
      cnt     <= '0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CntW'(1) && !pendDbz) begin
        hiReg <= pendHi;
        loReg <= pendLo;
      end
    end else if (op_valid) begin
      case (mdu_op)
        MDU_OP_MULT, MDU_OP_MULTU: begin
          pendHi  <= arith.hi;
          pendLo  <= arith.lo;
          pendDbz <= 1'b0;
          cnt     <= CntW'(MULT_CYCLES);
        end
        MDU_OP_DIV, MDU_OP_DIVU: begin
          pendHi  <= arith.hi;
          pendLo  <= arith.lo;
          pendDbz <= arith.divByZero;
          cnt     <= CntW'(DIV_CYCLES);
        end
        MDU_OP_MTHI: hiReg <= rs_data;
        MDU_OP_MTLO: loReg <= rs_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed checks of mdu_hilo: latencies, mult/div results, moves, divide-by-zero and reset abort.
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [MDU_OP_W-1:0] mdu_op;
  logic                op_valid;
  logic [31:0]         rs_data, rt_data;
  logic                busy;
  logic [31:0]         mdu_result, hi_out, lo_out;

  int checks = 0;
  int errors = 0;
  int n;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .mdu_op     (mdu_op),
    .op_valid   (op_valid),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .busy       (busy),
    .mdu_result (mdu_result),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left on a negedge; the op is presented for exactly one rising edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mdu_op = op; op_valid = 1'b1; rs_data = a; rt_data = b;
    @(negedge clk);
    op_valid = 1'b0; mdu_op = MDU_OP_NONE;
  endtask

  task automatic waitIdle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 64) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic readReg(input logic [3:0] op, output logic [31:0] val);
    mdu_op = op; op_valid = 1'b1;
    #1 val = mdu_result;
    op_valid = 1'b0; mdu_op = MDU_OP_NONE;
  endtask

  logic [31:0] rd;

  initial begin
    reset = 1'b1; mdu_op = MDU_OP_NONE; op_valid = 1'b0; rs_data = '0; rt_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_result", mdu_result, 32'd0);

    issue(MDU_OP_MULT, 32'hFFFF_FFFF, 32'd2);
    waitIdle(n);
    chk("mult_busy", n, 32'd5);
    chk("mult_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", lo_out, 32'hFFFF_FFFE);
    readReg(MDU_OP_MFLO, rd);
    chk("mult_mflo", rd, 32'hFFFF_FFFE);

    issue(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    waitIdle(n);
    chk("multu_busy", n, 32'd5);
    chk("multu_hi", hi_out, 32'h0000_0001);
    chk("multu_lo", lo_out, 32'hFFFF_FFFE);

    issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    waitIdle(n);
    chk("div_busy", n, 32'd10);
    chk("div_lo", lo_out, 32'hFFFF_FFFD);
    chk("div_hi", hi_out, 32'hFFFF_FFFF);

    issue(MDU_OP_DIVU, 32'd100, 32'd7);
    waitIdle(n);
    chk("divu_lo", lo_out, 32'd14);
    chk("divu_hi", hi_out, 32'd2);

    issue(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(n);
    chk("divovf_lo", lo_out, 32'h8000_0000);
    chk("divovf_hi", hi_out, 32'd0);

    issue(MDU_OP_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    readReg(MDU_OP_MFHI, rd);
    chk("mfhi", rd, 32'h1234_5678);
    @(negedge clk);
    issue(MDU_OP_MTLO, 32'hCAFE_BABE, 32'd0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    readReg(MDU_OP_MFLO, rd);
    chk("mflo", rd, 32'hCAFE_BABE);
    @(negedge clk);

    // Divide by zero, with a MULT attempted in the busy window.
    issue(MDU_OP_MTHI, 32'hAAAA_0000, 32'd0);
    issue(MDU_OP_MTLO, 32'h0000_BBBB, 32'd0);
    issue(MDU_OP_DIV, 32'd55, 32'd0);
    issue(MDU_OP_MULT, 32'd3, 32'd4);
    waitIdle(n);
    chk("dbz_busy_rest", n, 32'd9);
    chk("dbz_hi", hi_out, 32'hAAAA_0000);
    chk("dbz_lo", lo_out, 32'h0000_BBBB);

    // Reset on the third cycle of a MULT aborts it.
    issue(MDU_OP_MULT, 32'd5, 32'd6);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi_out, 32'd0);
    chk("abort_lo", lo_out, 32'd0);
    readReg(MDU_OP_MFLO, rd);
    chk("abort_result", rd, 32'd0);
    issue(MDU_OP_MULT, 32'd3, 32'd4);
    waitIdle(n);
    chk("post_rst_busy", n, 32'd5);
    chk("post_rst_lo", lo_out, 32'd12);
    chk("post_rst_hi", hi_out, 32'd0);

    // Unqualified op must not start anything.
    mdu_op = MDU_OP_MULT; op_valid = 1'b0; rs_data = 32'd7; rt_data = 32'd7;
    @(negedge clk);
    mdu_op = MDU_OP_NONE;
    chk("inval_busy", {31'd0, busy}, 32'd0);
    chk("inval_lo", lo_out, 32'd12);
    chk("inval_hi", hi_out, 32'd0);

    // MULT on the first idle cycle after a DIV.
    issue(MDU_OP_DIV, 32'd100, 32'd10);
    waitIdle(n);
    chk("b2b_div_busy", n, 32'd10);
    chk("b2b_div_lo", lo_out, 32'd10);
    chk("b2b_div_hi", hi_out, 32'd0);
    issue(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd4);
    chk("b2b_mult_accept", {31'd0, busy}, 32'd1);
    waitIdle(n);
    chk("b2b_mult_busy", n, 32'd5);
    chk("b2b_mult_lo", lo_out, 32'hFFFF_FFF4);
    chk("b2b_mult_hi", hi_out, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the ALU.
- Consumes the forwarded rs/rt operands produced by the EX-stage operand select muxes.
- Produces mdu_result, which feeds the EX result select mux and the EX/MEM pipeline register.
- Exposes busy so the hazard unit can stall decode-stage MDU instructions.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy duration for div/divu (must be >= 1)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all state
- mdu_op  input  4  operation code (encodings under Behaviour)
- op_valid  input  1  qualifies mdu_op; low when EX holds a bubble/flushed instruction
- rs_data  input  32  forwarded rs operand
- rt_data  input  32  forwarded rt operand
- busy  output  1  multi-cycle operation in flight
- mdu_result  output  32  HI for MFHI, LO for MFLO, else 0
- hi_out  output  32  current HI register (debug/trace)
- lo_out  output  32  current LO register (debug/trace)

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high.
- Reset: HI=0, LO=0, busy=0, counter=0, pending result discarded. Reset mid-operation aborts it; HI/LO stay 0.
- mdu_op encodings: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO. Codes 9-15 are treated as NONE.
- An op is accepted only when op_valid=1 and busy=0. When busy=1, all ops other than MFHI/MFLO are ignored. The hazard unit guarantees this does not occur architecturally.
- Start (ops 1-4): at the accepting edge:
  - Compute the 64-bit result from rs_data/rt_data and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; set busy=1.
- Each later edge while busy: decrement counter. At the edge where counter==1: write HI/LO from pending, clear busy.
- Net timing: busy is high for exactly N cycles after the start edge, and the new HI/LO are visible in the cycle busy first reads 0.
- MULT: {HI,LO} = signed(rs)*signed(rt), full 64 bits. MULTU: unsigned product.
- DIV:
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt=0, DIV or DIVU): still busy for DIV_CYCLES; HI/LO unchanged at completion.
- MTHI/MTLO: HI (resp. LO) = rs_data at the accepting edge; no busy.
- MFHI/MFLO: combinational, mdu_result = current HI/LO register. Not gated by busy; the stale value during busy is legal because the hazard unit stalls.
- mdu_result is 0 for every other op or when op_valid=0.
- Start and completion on the same edge: cannot occur, since starts are refused while busy=1. Back-to-back start on the first cycle with busy=0 is accepted.
- MTHI/MTLO when the previous op completes on the same edge: the op is not accepted, because busy was still 1.

Decomposition:
- Shared package mdu_pkg holds:
  - MDU_OP_* encoding constants and the 4-bit op width
  - default MULT_CYCLES/DIV_CYCLES localparams, also used by the hazard unit
- Natural sub-module: mdu_arith. It is purely combinational: op, rs, rt in; 64-bit {hi,lo} plus div_by_zero flag out.
- mdu_hilo keeps the counter, busy, pending and HI/LO registers.

Test Plan:
- MULT, rs=0xFFFFFFFF, rt=2 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV, rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- MTHI 0x12345678, then MFHI next cycle -> mdu_result=0x12345678. MTLO 0xCAFEBABE, then MFLO -> 0xCAFEBABE. Neither op raises busy.
- DIV by rt=0 with HI=0xAAAA0000, LO=0x0000BBBB -> busy 10 cycles, HI/LO unchanged. MULT issued while busy is ignored, and the old values persist.
- Reset asserted on cycle 3 of a MULT -> next cycle busy=0, HI=LO=0, mdu_result=0. A following MULT 3*4 -> LO=12, HI=0 after 5 cycles.
- op_valid=0 with mdu_op=MULT -> no busy, HI/LO unchanged. MULT accepted on the first busy=0 cycle after a DIV -> both results are correct in sequence.
